// File: rtl/flex_timer.sv
// rtl/flex_timer.sv - up/down counter with prescaler and wrap/saturate/one-shot terminal modes
module flex_timer #(
    parameter int NUM_CNT_BITS  = 8,
    parameter int PRESCALE_BITS = 4
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     clear,
    input  logic                     load,
    input  logic [NUM_CNT_BITS-1:0]  load_val,
    input  logic [NUM_CNT_BITS-1:0]  reset_val,
    input  logic [NUM_CNT_BITS-1:0]  rollover_val,
    input  logic                     count_enable,
    input  logic                     dir,
    input  logic [1:0]               mode,
    input  logic [PRESCALE_BITS-1:0] prescale_val,
    output logic [NUM_CNT_BITS-1:0]  count_out,
    output logic                     rollover_flag,
    output logic                     rollover_pulse,
    output logic                     active,
    output logic                     done
);

    typedef enum logic {RUN, HALT} state_t;

    localparam logic [NUM_CNT_BITS-1:0] ONE = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

    state_t                   state, state_next;
    logic [PRESCALE_BITS-1:0] pre, pre_next;
    logic [NUM_CNT_BITS-1:0]  count_next, terminal;
    logic                     flag_next, pulse_next;
    logic                     tick, live, at_term, oneshot, saturate;

    always_ff @(posedge clk, negedge n_rst) begin
        if (!n_rst) begin
            state          <= RUN;
            pre            <= '0;
            count_out      <= '0;
            rollover_flag  <= 1'b0;
            rollover_pulse <= 1'b0;
        end else begin
            state          <= state_next;
            pre            <= pre_next;
            count_out      <= count_next;
            rollover_flag  <= flag_next;
            rollover_pulse <= pulse_next;
        end
    end

    always_comb begin
        terminal   = dir ? ONE : rollover_val;
        live       = (rollover_val != '0);
        saturate   = (mode == 2'b01);
        oneshot    = (mode == 2'b10);
        // >= so that lowering prescale_val below the running prescaler ticks at once
        tick       = count_enable && (state == RUN) && (pre >= prescale_val);
        at_term    = dir ? (count_out <= ONE) : (count_out >= rollover_val);

        state_next = state;
        pre_next   = pre;
        count_next = count_out;
        flag_next  = rollover_flag;
        pulse_next = 1'b0;

        if (clear) begin
            count_next = reset_val;
            pre_next   = '0;
            state_next = RUN;
            flag_next  = (reset_val == terminal) && live;
        end else if (load) begin
            count_next = load_val;
            pre_next   = '0;
            state_next = RUN;
            flag_next  = (load_val == terminal) && live;
        end else if (tick) begin
            pre_next = '0;
            if (live) begin
                if (at_term) begin
                    if (oneshot)
                        state_next = HALT;
                    else if (saturate)
                        count_next = terminal;
                    else
                        count_next = dir ? rollover_val : ONE;
                end else if (dir) begin
                    count_next = (count_out > rollover_val) ? rollover_val : count_out - ONE;
                end else begin
                    count_next = count_out + ONE;
                end
                pulse_next = (count_next == terminal) && (count_out != terminal);
            end
            flag_next = (count_next == terminal) && live;
        end else begin
            if (count_enable && (state == RUN))
                pre_next = pre + 1'b1;
            // the flag is frozen once a one-shot has finished
            if (state == RUN)
                flag_next = (count_out == terminal) && live;
        end
    end

    assign active = (state == RUN);
    assign done   = (state == HALT);

endmodule

// File: tb/tb_flex_timer.sv
// tb/tb_flex_timer.sv - table, directed and randomized checks of flex_timer against a behavioural model
module tb_flex_timer;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       clear, load, count_enable, dir;
    logic [7:0] load_val, reset_val, rollover_val;
    logic [1:0] mode;
    logic [3:0] prescale_val;
    logic [7:0] count_out;
    logic       rollover_flag, rollover_pulse, active, done;

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model state
    int m_cnt, m_pre;
    bit m_flag, m_pulse, m_halt;

    flex_timer #(.NUM_CNT_BITS(8), .PRESCALE_BITS(4)) dut (
        .clk(clk), .n_rst(n_rst), .clear(clear), .load(load),
        .load_val(load_val), .reset_val(reset_val), .rollover_val(rollover_val),
        .count_enable(count_enable), .dir(dir), .mode(mode), .prescale_val(prescale_val),
        .count_out(count_out), .rollover_flag(rollover_flag), .rollover_pulse(rollover_pulse),
        .active(active), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit clr; bit ld; int lv; int rst_v; int rv; bit en; bit dn; int md; int ps;
        int e_cnt; bit e_flag; bit e_pulse; bit e_done;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_pre = 0; m_flag = 0; m_pulse = 0; m_halt = 0;
    endtask

    // One clock of the specification's rules, using the inputs held across the edge.
    task automatic model_step();
        int rv, term, old, nxt;
        bit tk;
        rv   = int'(rollover_val);
        term = dir ? 1 : rv;
        tk   = count_enable && !m_halt && (m_pre >= int'(prescale_val));
        m_pulse = 0;
        if (clear || load) begin
            m_cnt  = clear ? int'(reset_val) : int'(load_val);
            m_pre  = 0;
            m_halt = 0;
            m_flag = (rv != 0) && (m_cnt == term);
        end else if (tk) begin
            m_pre = 0;
            old = m_cnt;
            nxt = m_cnt;
            if (rv != 0) begin
                if (!dir) begin
                    if (old < rv) nxt = old + 1;
                    else if (mode == 2'b10) m_halt = 1;
                    else if (mode == 2'b01) nxt = rv;
                    else nxt = 1;
                end else begin
                    if (old > rv) nxt = rv;
                    else if (old > 1) nxt = old - 1;
                    else if (mode == 2'b10) m_halt = 1;
                    else if (mode == 2'b01) nxt = 1;
                    else nxt = rv;
                end
                m_pulse = (nxt == term) && (old != term);
            end
            m_cnt  = nxt;
            m_flag = (rv != 0) && (nxt == term);
        end else begin
            if (count_enable && !m_halt) m_pre = m_pre + 1;
            if (!m_halt) m_flag = (rv != 0) && (m_cnt == term);
        end
    endtask

    task automatic check_model();
        check("count", int'(count_out), m_cnt);
        check("flag", int'(rollover_flag), int'(m_flag));
        check("pulse", int'(rollover_pulse), int'(m_pulse));
        check("done", int'(done), int'(m_halt));
        check("active", int'(active), int'(!m_halt));
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        check_model();
    endtask

    task automatic set_in(input bit clr, input bit ld, input int lv, input int rst_v, input int rv,
                          input bit en, input bit dn, input int md, input int ps);
        clear = clr; load = ld; load_val = 8'(lv); reset_val = 8'(rst_v); rollover_val = 8'(rv);
        count_enable = en; dir = dn; mode = 2'(md); prescale_val = 4'(ps);
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        #2;
        model_reset();
        n_rst = 1'b1;
    endtask

    vec_t vecs[$];

    initial begin
        // wrap up, rollover 4
        for (int i = 0; i < 6; i++)
            vecs.push_back('{0,0,0,0,4,1,0,0,0, (i % 4) + 1, (i % 4) == 3, (i % 4) == 3, 0});
        // down wrap from load 5
        vecs.push_back('{0,1,5,0,5,1,1,0,0, 5,0,0,0});
        vecs.push_back('{0,0,0,0,5,1,1,0,0, 4,0,0,0});
        vecs.push_back('{0,0,0,0,5,1,1,0,0, 3,0,0,0});
        vecs.push_back('{0,0,0,0,5,1,1,0,0, 2,0,0,0});
        vecs.push_back('{0,0,0,0,5,1,1,0,0, 1,1,1,0});
        vecs.push_back('{0,0,0,0,5,1,1,0,0, 5,0,0,0});
        // one-shot up, rollover 3
        vecs.push_back('{1,0,0,0,3,1,0,2,0, 0,0,0,0});
        vecs.push_back('{0,0,0,0,3,1,0,2,0, 1,0,0,0});
        vecs.push_back('{0,0,0,0,3,1,0,2,0, 2,0,0,0});
        vecs.push_back('{0,0,0,0,3,1,0,2,0, 3,1,1,0});
        vecs.push_back('{0,0,0,0,3,1,0,2,0, 3,1,0,1});
        vecs.push_back('{0,0,0,0,3,1,0,2,0, 3,1,0,1});
        vecs.push_back('{0,1,0,0,3,1,0,2,0, 0,0,0,0});
        vecs.push_back('{0,0,0,0,3,1,0,2,0, 1,0,0,0});

        set_in(0,0,0,0,0,0,0,0,0);
        do_reset();
        #1;
        check("rst_count", int'(count_out), 0);
        check("rst_flag", int'(rollover_flag), 0);
        check("rst_pulse", int'(rollover_pulse), 0);
        check("rst_active", int'(active), 1);
        check("rst_done", int'(done), 0);

        foreach (vecs[i]) begin
            set_in(vecs[i].clr, vecs[i].ld, vecs[i].lv, vecs[i].rst_v, vecs[i].rv,
                   vecs[i].en, vecs[i].dn, vecs[i].md, vecs[i].ps);
            cycle();
            check($sformatf("vec%0d_count", i), int'(count_out), vecs[i].e_cnt);
            check($sformatf("vec%0d_flag", i), int'(rollover_flag), int'(vecs[i].e_flag));
            check($sformatf("vec%0d_pulse", i), int'(rollover_pulse), int'(vecs[i].e_pulse));
            check($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].e_done));
        end

        // prescale 2 with enable gap mid-prescale
        set_in(1,0,0,0,3,0,0,0,2); cycle();
        set_in(0,0,0,0,3,1,0,0,2); cycle(); cycle();
        check("ps_before", int'(count_out), 0);
        set_in(0,0,0,0,3,0,0,0,2);
        for (int i = 0; i < 5; i++) cycle();
        check("ps_hold", int'(count_out), 0);
        set_in(0,0,0,0,3,1,0,0,2); cycle();
        check("ps_resume", int'(count_out), 1);
        cycle(); cycle();
        check("ps_mid", int'(count_out), 1);
        cycle();
        check("ps_second", int'(count_out), 2);

        // saturate up at 6, then lower rollover to 4
        set_in(1,0,0,0,6,1,0,1,0); cycle();
        set_in(0,0,0,0,6,1,0,1,0);
        for (int i = 0; i < 8; i++) cycle();
        check("sat_count", int'(count_out), 6);
        check("sat_flag", int'(rollover_flag), 1);
        check("sat_nopulse", int'(rollover_pulse), 0);
        set_in(0,0,0,0,4,1,0,1,0); cycle();
        check("sat_lower_count", int'(count_out), 4);
        check("sat_lower_flag", int'(rollover_flag), 1);

        // clear beats load and tick
        set_in(1,1,2,7,3,1,0,0,2); cycle();
        check("clr_wins", int'(count_out), 7);
        set_in(0,0,2,7,3,1,0,0,2); cycle();
        check("clr_pre0", int'(count_out), 7);
        cycle(); cycle();
        check("clr_wrap", int'(count_out), 1);

        // async reset mid-count
        set_in(0,0,0,0,4,1,0,0,0); cycle(); cycle();
        #3;
        n_rst = 1'b0;
        #1;
        check("arst_count", int'(count_out), 0);
        check("arst_flag", int'(rollover_flag), 0);
        check("arst_pulse", int'(rollover_pulse), 0);
        check("arst_active", int'(active), 1);
        model_reset();
        @(negedge clk);
        n_rst = 1'b1;

        // randomized against the model
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0,
                   $urandom_range(0, 12), $urandom_range(0, 12),
                   ($urandom_range(0, 9) == 0) ? $urandom_range(0, 12) : int'(rollover_val),
                   $urandom_range(0, 3) != 0,
                   ($urandom_range(0, 29) == 0) ? !dir : dir,
                   ($urandom_range(0, 29) == 0) ? $urandom_range(0, 3) : int'(mode),
                   ($urandom_range(0, 19) == 0) ? $urandom_range(0, 3) : int'(prescale_val));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
